multi_channel_timer: RTL and testbench
======================================

// Module: multi_channel_timer
// PURPOSE
//   Parametrised N-channel programmable timer for the RC control fabric. Each channel
//   has a runtime load value, one-shot or periodic mode, retrigger and cancel.
//   Per channel it outputs a one-cycle expiry pulse, a sticky expiry flag and a shared irq.
//   It is the generalised replacement for the fixed 100 ms one-shot timer.
//   It services steering, throttle and watchdog timeouts from one instance.
// PARAMETERS
//   NUM_CH    4    number of independent channels (1..16)
//   CNT_W     24   width of load value / tick counter per channel
//   PRESCALE  1    clk cycles per counter tick (>=1); 125 => 1 us tick at 125 MHz
// PORTS
//   clk          in   1            system clock (125 MHz)
//   reset        in   1            asynchronous, active-high
//   start        in   NUM_CH       per-channel start/retrigger strobe
//   stop         in   NUM_CH       per-channel cancel strobe
//   periodic     in   NUM_CH       mode, sampled at start: 1=auto-reload, 0=one-shot
//   load_val     in   NUM_CH*CNT_W ticks to expiry; ch i = load_val[i*CNT_W +: CNT_W]
//   flag_clr     in   NUM_CH       clears expired_flag[i]
//   active       out  NUM_CH       channel running
//   expired      out  NUM_CH       one-cycle pulse at each expiry
//   expired_flag out  NUM_CH       sticky expiry status
//   irq          out  1            OR of expired_flag
// BEHAVIOUR
// - Reset state: all outputs 0, all counters, prescalers and stored load/mode registers 0.
//   Reset mid-count aborts every channel with no expiry pulse.
// - Latching at start: start[i] at edge E0 latches load_val slice (L) and periodic[i].
//   It zeroes the channel prescaler and tick counter and sets active[i]=1.
//   L==0 is treated as L=1.
// - Counting: the prescaler counts 0..PRESCALE-1 each clk while active.
//   The tick counter increments when the prescaler wraps.
// - Latency: expired[i] is high for exactly one cycle following edge E0 + L*PRESCALE.
//   This matches legacy timing: L=N, PRESCALE=1 gives a pulse after edge E0+N.
// - Expiry, one-shot: active[i] drops in the same edge expired[i] rises.
// - Expiry, periodic: counters reload to 0 and active[i] stays 1.
//   Pulses repeat every L*PRESCALE cycles until stop.
// - Retrigger: start while active restarts from 0 with the new L and mode.
//   No pulse is emitted for the abandoned interval.
// - Cancel: stop[i] clears active[i] and the counters next edge, with no pulse.
//   stop while idle has no effect.
// - Priority per channel: stop > start > expiry.
//   start coinciding with the expiry edge restarts and suppresses that pulse.
//   stop coinciding with the expiry edge suppresses it.
// - Sticky flag: expired_flag[i] is set on each expired pulse and cleared by flag_clr[i].
//   If set and clear coincide, set wins.
//   irq is a registered OR, high one cycle after any flag is set.
// - Channel independence: channels are fully independent.
//   Simultaneous events on different channels all take effect in the same cycle.
// - Width: counter compares equality to L-1 on tick; no overflow is possible.
//   L max is 2^CNT_W-1.
// TESTING
// 1. PRESCALE=1, ch0 one-shot, L=10, start at E0.
//    -> expired[0] high only after E10; active[0] high E1..E10; flag and irq set.
// 2. Ch1 periodic, L=5.
//    -> pulses after E5, E10, E15; stop at E12 -> active low after E13, no pulse at E15.
// 3. Ch2 L=8, restart at E6 with L=3.
//    -> no pulse at E8; single pulse after E9.
// 4. Ch0 L=4, start and stop asserted together.
//    -> channel stays idle; start on the expiry edge -> pulse suppressed, restart from 0.
// 5. PRESCALE=3, L=4 -> pulse after E12; L=0 -> pulse after E3.
//    Reset asserted at E2 of any run -> all outputs 0, no pulse.
// 6. All 4 channels started together with L=1,2,3,4 -> pulses on E1..E4 respectively.
//    flag_clr[0] on the same edge as ch0's pulse -> flag stays set.

Source files
------------

// File: rtl/multi_channel_timer.sv
// N-channel programmable timer with per-channel one-shot/periodic modes.
// Each channel raises a one-cycle expiry pulse and a sticky flag; irq is the OR of those flags.
module multi_channel_timer #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 24,
  parameter int PRESCALE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*CNT_W-1:0] load_val,
  input  logic [NUM_CH-1:0]       flag_clr,
  output logic [NUM_CH-1:0]       active,
  output logic [NUM_CH-1:0]       expired,
  output logic [NUM_CH-1:0]       expired_flag,
  output logic                    irq
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PRE_W-1:0] pre_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] term_q;
    logic             periodic_q;
    logic             active_q;
    logic             expired_q;
    logic             flag_q;
    logic [CNT_W-1:0] load_slice;
    logic             tick;
    logic             hit;
    logic             fire;

    assign load_slice = load_val[i*CNT_W +: CNT_W];
    assign tick       = active_q && (pre_q == PRE_LAST);
    assign hit        = tick && (cnt_q == term_q);
    // stop and start both outrank an expiry landing on the same edge
    assign fire       = hit && !stop[i] && !start[i];

    // The terminal count L-1 is stored rather than L; a load of 0 behaves like 1.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pre_q      <= '0;
        cnt_q      <= '0;
        term_q     <= '0;
        periodic_q <= 1'b0;
        active_q   <= 1'b0;
        expired_q  <= 1'b0;
        flag_q     <= 1'b0;
      end else begin
        expired_q <= fire;
        flag_q    <= fire | (flag_q & ~flag_clr[i]);
        if (stop[i]) begin
          active_q <= 1'b0;
          pre_q    <= '0;
          cnt_q    <= '0;
        end else if (start[i]) begin
          active_q   <= 1'b1;
          pre_q      <= '0;
          cnt_q      <= '0;
          periodic_q <= periodic[i];
          term_q     <= (load_slice == '0) ? '0 : load_slice - CNT_W'(1);
        end else if (active_q) begin
          if (hit) begin
            pre_q <= '0;
            cnt_q <= '0;
            if (!periodic_q)
              active_q <= 1'b0;
          end else if (tick) begin
            pre_q <= '0;
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            pre_q <= pre_q + PRE_W'(1);
          end
        end
      end
    end

    assign active[i]       = active_q;
    assign expired[i]      = expired_q;
    assign expired_flag[i] = flag_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      irq <= 1'b0;
    else
      irq <= |expired_flag;
  end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer: a PRESCALE=1 instance and a PRESCALE=3 instance.
// Expected values are hand-computed edge by edge from the start edge E0.
module tb_multi_channel_timer;

  localparam int N = 4;
  localparam int W = 24;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [N-1:0]   start_a = '0, stop_a = '0, periodic_a = '0, clr_a = '0;
  logic [N*W-1:0] load_a = '0;
  logic [N-1:0]   active_a, expired_a, flag_a;
  logic           irq_a;

  logic [N-1:0]   start_b = '0, stop_b = '0, periodic_b = '0, clr_b = '0;
  logic [N*W-1:0] load_b = '0;
  logic [N-1:0]   active_b, expired_b, flag_b;
  logic           irq_b;

  int num_checks = 0;
  int num_failures = 0;

  always #5 clk = ~clk;

  multi_channel_timer #(.NUM_CH(N), .CNT_W(W), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .stop(stop_a), .periodic(periodic_a),
    .load_val(load_a), .flag_clr(clr_a), .active(active_a), .expired(expired_a),
    .expired_flag(flag_a), .irq(irq_a));

  multi_channel_timer #(.NUM_CH(N), .CNT_W(W), .PRESCALE(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .stop(stop_b), .periodic(periodic_b),
    .load_val(load_b), .flag_clr(clr_b), .active(active_b), .expired(expired_b),
    .expired_flag(flag_b), .irq(irq_b));

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // advance to just after the next rising edge; inputs set here are seen at the following edge
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int ch, input int load, input logic mode);
    load_a[ch*W +: W] = W'(load);
    periodic_a[ch]    = mode;
    start_a[ch]       = 1'b1;
  endtask

  initial begin
    next_edge();
    next_edge();
    checkOutput("reset_active", {28'd0, active_a}, 0);
    checkOutput("reset_expired", {28'd0, expired_a}, 0);
    checkOutput("reset_flag", {28'd0, flag_a}, 0);
    checkOutput("reset_irq", {31'd0, irq_a}, 0);
    reset = 1'b0;
    next_edge();

    // one-shot L=10 on ch0
    applyStimulus(0, 10, 1'b0);
    next_edge();
    start_a = '0;
    checkOutput("t1_active_e0", {31'd0, active_a[0]}, 1);
    for (int k = 1; k <= 10; k++) begin
      next_edge();
      checkOutput($sformatf("t1_exp_e%0d", k), {31'd0, expired_a[0]}, (k == 10) ? 1 : 0);
      checkOutput($sformatf("t1_act_e%0d", k), {31'd0, active_a[0]}, (k < 10) ? 1 : 0);
    end
    checkOutput("t1_flag", {31'd0, flag_a[0]}, 1);
    checkOutput("t1_irq_e10", {31'd0, irq_a}, 0);
    next_edge();
    checkOutput("t1_irq_e11", {31'd0, irq_a}, 1);
    checkOutput("t1_exp_e11", {31'd0, expired_a[0]}, 0);
    clr_a[0] = 1'b1;
    next_edge();
    clr_a[0] = 1'b0;
    checkOutput("t1_flag_clr", {31'd0, flag_a[0]}, 0);
    checkOutput("t1_irq_hold", {31'd0, irq_a}, 1);
    next_edge();
    checkOutput("t1_irq_drop", {31'd0, irq_a}, 0);

    // periodic L=5 on ch1, stopped so it is sampled at E13
    applyStimulus(1, 5, 1'b1);
    next_edge();
    start_a = '0;
    periodic_a = '0;
    for (int k = 1; k <= 16; k++) begin
      next_edge();
      stop_a[1] = 1'b0;
      checkOutput($sformatf("t2_exp_e%0d", k), {31'd0, expired_a[1]},
                  (k == 5 || k == 10) ? 1 : 0);
      checkOutput($sformatf("t2_act_e%0d", k), {31'd0, active_a[1]}, (k < 13) ? 1 : 0);
      if (k == 12) stop_a[1] = 1'b1;
    end

    // ch2 L=8 retriggered at E6 with L=3
    applyStimulus(2, 8, 1'b0);
    next_edge();
    start_a = '0;
    for (int k = 1; k <= 12; k++) begin
      next_edge();
      start_a = '0;
      checkOutput($sformatf("t3_exp_e%0d", k), {31'd0, expired_a[2]}, (k == 9) ? 1 : 0);
      checkOutput($sformatf("t3_act_e%0d", k), {31'd0, active_a[2]}, (k < 9) ? 1 : 0);
      if (k == 5) applyStimulus(2, 3, 1'b0);
    end

    // ch0 start+stop together stays idle
    applyStimulus(0, 4, 1'b0);
    stop_a[0] = 1'b1;
    next_edge();
    start_a = '0;
    stop_a = '0;
    checkOutput("t4_idle_a", {31'd0, active_a[0]}, 0);
    next_edge();
    checkOutput("t4_idle_b", {28'd0, active_a | expired_a}, 0);

    // ch0 L=4 restarted on its expiry edge E4
    applyStimulus(0, 4, 1'b0);
    next_edge();
    start_a = '0;
    for (int k = 1; k <= 9; k++) begin
      next_edge();
      start_a = '0;
      checkOutput($sformatf("t4_exp_e%0d", k), {31'd0, expired_a[0]}, (k == 8) ? 1 : 0);
      checkOutput($sformatf("t4_act_e%0d", k), {31'd0, active_a[0]}, (k < 8) ? 1 : 0);
      if (k == 3) applyStimulus(0, 4, 1'b0);
    end

    // all channels L=1..4 together; clear ch0 flag on its pulse edge
    clr_a = '1;
    next_edge();
    clr_a = '0;
    checkOutput("t6_flags_clr", {28'd0, flag_a}, 0);
    for (int c = 0; c < N; c++) applyStimulus(c, c + 1, 1'b0);
    next_edge();
    start_a = '0;
    clr_a[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      next_edge();
      clr_a = '0;
      checkOutput($sformatf("t6_exp_e%0d", k), {28'd0, expired_a},
                  (k <= 4) ? (32'd1 << (k - 1)) : 0);
      if (k == 1) checkOutput("t6_flag0_setwins", {31'd0, flag_a[0]}, 1);
    end
    checkOutput("t6_flags_all", {28'd0, flag_a}, 32'hF);
    checkOutput("t6_active_none", {28'd0, active_a}, 0);

    // PRESCALE=3: L=4 expires at E12
    load_b[0 +: W] = W'(4);
    start_b[0] = 1'b1;
    next_edge();
    start_b = '0;
    for (int k = 1; k <= 13; k++) begin
      next_edge();
      checkOutput($sformatf("t5_exp_e%0d", k), {31'd0, expired_b[0]}, (k == 12) ? 1 : 0);
    end
    // PRESCALE=3: L=0 behaves as L=1, expires at E3
    load_b[0 +: W] = '0;
    start_b[0] = 1'b1;
    next_edge();
    start_b = '0;
    for (int k = 1; k <= 4; k++) begin
      next_edge();
      checkOutput($sformatf("t5z_exp_e%0d", k), {31'd0, expired_b[0]}, (k == 3) ? 1 : 0);
    end

    // reset just after E2 aborts running channels on both instances
    applyStimulus(0, 3, 1'b0);
    load_b[0 +: W] = W'(2);
    start_b[0] = 1'b1;
    next_edge();
    start_a = '0;
    start_b = '0;
    next_edge();
    next_edge();
    reset = 1'b1;
    #1;
    checkOutput("t5r_a_outs", {active_a, expired_a, flag_a, 20'd0, 3'd0, irq_a}, 0);
    checkOutput("t5r_b_outs", {active_b, expired_b, flag_b, 20'd0, 3'd0, irq_b}, 0);
    next_edge();
    next_edge();
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      next_edge();
      checkOutput($sformatf("t5r_quiet_%0d", k),
                  {20'd0, expired_a, active_a, expired_b, active_b}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
    $finish;
  end

endmodule
